// File: rtl/pcie_consts.sv
//------------------------------------------------------------------------------
// Module      : pcie_consts
// Description : Shared widths and record types for the queue/descriptor path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pcie_consts;

    localparam int RB_AWIDTH     = 16;
    localparam int APP_IDX_WIDTH = 13;

    typedef struct packed {
        logic [APP_IDX_WIDTH-1:0] queue_id;
        logic [RB_AWIDTH-1:0]     head;
    } head_upd_t;

    typedef struct packed {
        logic [APP_IDX_WIDTH-1:0] dsc_queue_id;
        logic [APP_IDX_WIDTH-1:0] pkt_queue_id;
        logic [15:0]              size;
        logic                     descriptor_only;
        logic                     needs_dsc;
        logic                     drop_data;
        logic                     drop_meta;
    } pkt_meta_with_queues_t;

    function automatic pkt_meta_with_queues_t dsc_only_meta(input logic [APP_IDX_WIDTH-1:0] qid);
        pkt_meta_with_queues_t m;
        m                 = '0;
        m.descriptor_only = 1'b1;
        m.pkt_queue_id    = qid;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_interface_io.sv
//------------------------------------------------------------------------------
// Module      : bram_interface_io
// Description : Simple single-port BRAM access bundle (owner drives the port).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bram_interface_io #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  rd_en;

    modport owner (output addr, output wr_data, output wr_en, output rd_en);
    modport user  (input  addr, input  wr_data, input  wr_en, input  rd_en);
endinterface

`default_nettype wire

// File: rtl/fifo_wrapper_infill_mlab.sv
//------------------------------------------------------------------------------
// Module      : fifo_wrapper_infill_mlab
// Description : Show-ahead FIFO with occupancy output; head entry is visible
//               combinationally from the storage array.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wrapper_infill_mlab #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_valid_i,
    output logic [WIDTH-1:0]         out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             w_push, w_pop;

    always_comb begin
        w_push   = in_valid_i && (cnt_q != FULL);
        w_pop    = out_ready_i && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(w_push);
        rd_ptr_d = rd_ptr_q + AW'(w_pop);
        cnt_d    = cnt_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_valid_o = (cnt_q != '0);
    assign occupancy_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/head_update_coalescer.sv
//------------------------------------------------------------------------------
// Module      : head_update_coalescer
// Description : Writes software head updates to the head table and emits one
//               descriptor-only request per queue while one is outstanding.
//               Coalescing is built only when HEAD_UPD_COALESCE_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module head_update_coalescer
    import pcie_consts::*;
#(
    parameter int NB_QUEUES  = 8192,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  head_upd_t             in_upd_data,
    input  logic                  in_upd_valid,
    output logic                  in_upd_ready,
    bram_interface_io.owner       q_table_heads,
    output pkt_meta_with_queues_t out_meta_data,
    output logic                  out_meta_valid,
    input  logic                  out_meta_ready,
    input  logic [RB_AWIDTH:0]    rb_size,
    output logic [31:0]           upd_cnt,
    output logic [31:0]           coalesced_cnt,
    output logic [31:0]           out_cnt
);
    localparam int               QW        = $clog2(NB_QUEUES);
    localparam int               OCC_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] READY_MAX = OCC_W'(FIFO_DEPTH - 3);

    logic [QW-1:0]            w_lq;
    logic [RB_AWIDTH-1:0]     w_mask;
    logic                     w_accept, w_pop, w_merge, w_fifo_push;
    logic [OCC_W-1:0]         w_occ;
    pkt_meta_with_queues_t    w_push_entry;

    logic                     stg_valid_q, stg_valid_d;
    logic                     stg_push_q, stg_push_d;
    logic [APP_IDX_WIDTH-1:0] stg_qid_q, stg_qid_d;
    logic [RB_AWIDTH-1:0]     stg_head_q, stg_head_d;
    logic [31:0]              upd_cnt_q, upd_cnt_d;
    logic [31:0]              out_cnt_q, out_cnt_d;

    // rb_size == 2^RB_AWIDTH has no low bits set; its MSB alone selects the full mask.
    assign w_mask = (rb_size[RB_AWIDTH-1:0] - 1'b1) | {RB_AWIDTH{rb_size[RB_AWIDTH]}};

    always_comb begin
        w_lq         = in_upd_data.queue_id[APP_IDX_WIDTH-1 -: QW];
        in_upd_ready = !rst && (w_occ <= READY_MAX);
        w_accept     = in_upd_valid && in_upd_ready;
        w_pop        = out_meta_valid && out_meta_ready;

        stg_valid_d  = w_accept;
        stg_push_d   = w_accept && !w_merge;
        stg_qid_d    = in_upd_data.queue_id;
        stg_head_d   = in_upd_data.head & w_mask;

        upd_cnt_d    = upd_cnt_q + 32'(w_accept);
        out_cnt_d    = out_cnt_q + 32'(w_pop);

        w_push_entry                 = '0;
        w_push_entry.descriptor_only = 1'b1;
        w_push_entry.pkt_queue_id    = stg_qid_q;
        w_fifo_push                  = stg_valid_q && stg_push_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_push_q  <= 1'b0;
            stg_qid_q   <= '0;
            stg_head_q  <= '0;
            upd_cnt_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_push_q  <= stg_push_d;
            stg_qid_q   <= stg_qid_d;
            stg_head_q  <= stg_head_d;
            upd_cnt_q   <= upd_cnt_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

`ifdef HEAD_UPD_COALESCE_EN
    logic [NB_QUEUES-1:0] pending_q;
    logic [QW-1:0]        w_pop_lq;
    logic [31:0]          coalesced_cnt_q;

    // A pop of the same queue in this cycle frees the slot, so the new update pushes.
    assign w_pop_lq = out_meta_data.pkt_queue_id[APP_IDX_WIDTH-1 -: QW];
    assign w_merge  = pending_q[w_lq] && !(w_pop && (w_pop_lq == w_lq));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q       <= '0;
            coalesced_cnt_q <= '0;
        end else begin
            if (w_pop) begin
                pending_q[w_pop_lq] <= 1'b0;
            end
            if (w_accept) begin
                pending_q[w_lq] <= 1'b1;
            end
            coalesced_cnt_q <= coalesced_cnt_q + 32'(w_accept && w_merge);
        end
    end

    assign coalesced_cnt = coalesced_cnt_q;
`else
    assign w_merge       = 1'b0;
    assign coalesced_cnt = '0;
`endif

    fifo_wrapper_infill_mlab #(
        .WIDTH ($bits(pkt_meta_with_queues_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (w_push_entry),
        .in_valid_i  (w_fifo_push),
        .out_data_o  (out_meta_data),
        .out_valid_o (out_meta_valid),
        .out_ready_i (out_meta_ready),
        .occupancy_o (w_occ)
    );

    assign q_table_heads.wr_en   = stg_valid_q && !rst;
    assign q_table_heads.addr    = stg_qid_q[APP_IDX_WIDTH-1 -: QW];
    assign q_table_heads.wr_data = stg_head_q;
    assign q_table_heads.rd_en   = 1'b0;

    assign upd_cnt = upd_cnt_q;
    assign out_cnt = out_cnt_q;

endmodule

`default_nettype wire
